serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), with
// borrow-out. One operand bit is processed per clock, LSB first, using a
// three-state FSM (IDLE -> RUN -> DONE -> IDLE).
//
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the 'ovf' output,
// the signed two's-complement overflow of the subtraction.
//
// Parameters:
//   WIDTH  operand / result width in bits (default 8)
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   start  request a subtraction (sampled only in IDLE)
//   a      minuend, captured on the accepting edge
//   b      subtrahend, captured on the accepting edge
//   bin    borrow-in, captured on the accepting edge
//   busy   high whenever the FSM is not in IDLE
//   done   one-cycle pulse while in DONE: diff/bout hold a new result
//   diff   registered result, updated only on DONE entry
//   bout   registered borrow-out, updated only on DONE entry
//   ovf    (SERIAL_SUBTRACTOR_OVF_EN only) signed overflow, updated on DONE entry
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;

  // One full-subtractor cell working on the current LSBs of the shifters.
  logic             ai;
  logic             bi;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    ai       = a_sh_reg[0];
    bi       = b_sh_reg[0];
    d_bit    = ai ^ bi ^ br_reg;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br_reg);
    // New bit enters from the MSB side; after WIDTH shifts the first
    // (LSB) result bit has reached position 0.
    res_next = WIDTH'({d_bit, res_sh_reg} >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            br_reg     <= bin;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= res_next;
          br_reg     <= br_next;
          if (cnt_reg == LAST_BIT) begin
            // Result outputs are loaded directly from the final cell so
            // they appear together with done in the DONE cycle.
            diff_reg  <= res_next;
            bout_reg  <= br_next;
            cnt_reg   <= '0;
            state_reg <= DONE_ST;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE_ST: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE_ST);
  assign diff = diff_reg;
  assign bout = bout_reg;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep copies.
  logic a_msb_reg;
  logic b_msb_reg;
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        a_msb_reg <= a[WIDTH-1];
        b_msb_reg <= b[WIDTH-1];
      end
      if (state_reg == RUN && cnt_reg == LAST_BIT) begin
        // The final cell output is the result MSB.
        ovf_reg <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
      end
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor (WIDTH=8). Each issued operation
// pushes its expected result and expected done cycle into a queue; a monitor
// running on the falling clock edge pops and compares on every done pulse,
// and otherwise checks busy and that diff/bout hold the last result.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  int           free_cyc = 0;
  int           busy_from = -1;
  int           busy_to = -1;
  bit           hold_mode = 1'b0;
  bit           monitor_on = 1'b0;
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;
  logic         held_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic binv, input int dc);
    exp_t e;
    int   r;
    int   sa;
    int   sbv;
    int   sr;
    r   = int'(av) - int'(bv) - int'(binv);
    sa  = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sbv = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
    sr  = sa - sbv - int'(binv);
    e.diff = r[W-1:0];
    e.bout = (r < 0);
    e.ovf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    e.cyc  = dc;
    return e;
  endfunction

  // Waits for the first falling edge from which the next rising edge is an
  // accepting edge, presents the operation, and records its expectation.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
    @(negedge clk);
    while (cyc + 1 < free_cyc) begin
      if (hold_mode) begin
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
      end
      @(negedge clk);
    end
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    sb.push_back(model(av, bv, binv, cyc + 1 + W));
    busy_from = cyc + 1;
    busy_to   = cyc + 1 + W;
    free_cyc  = cyc + 3 + W;
    $display("op: a=%0d b=%0d bin=%0d accept_cycle=%0d", av, bv, binv, cyc + 1);
    @(negedge clk);
    if (!hold_mode) start = 1'b0;
  endtask

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    if (monitor_on && rst_n) begin
      chk("busy", busy, (cyc >= busy_from && cyc <= busy_to));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("diff", diff, e.diff);
          chk("bout", bout, e.bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          chk("ovf", ovf, e.ovf);
`endif
          $display("result: diff=%0h bout=%0b exp_diff=%0h exp_bout=%0b cycle=%0d",
                   diff, bout, e.diff, e.bout, cyc);
          held_diff = e.diff;
          held_bout = e.bout;
          held_ovf  = e.ovf;
        end
      end else begin
        if (sb.size() != 0 && cyc >= sb[0].cyc) begin
          chk("missing_done", 0, 1);
          void'(sb.pop_front());
        end
        chk("diff_hold", diff, held_diff);
        chk("bout_hold", bout, held_bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf_hold", ovf, held_ovf);
`endif
      end
    end
  end

  initial begin
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    monitor_on = 1'b1;

    // Directed cases.
    issue(8'd100, 8'd37, 1'b0);
    issue(8'h00, 8'h01, 1'b0);
    issue(8'h05, 8'h05, 1'b1);
    issue(8'h80, 8'h01, 1'b0);
    issue(8'h5A, 8'h5A, 1'b0);
    issue(8'h00, 8'hFF, 1'b1);
    issue(8'h10, 8'h20, 1'b0);
    issue(8'h20, 8'h10, 1'b0);

    // Start held high with changing operands through RUN and DONE.
    hold_mode = 1'b1;
    issue(8'h33, 8'h44, 1'b0);
    issue(8'hC3, 8'h3C, 1'b1);
    hold_mode = 1'b0;
    start = 1'b0;

    // Reset asserted while RUN is processing bit 4.
    issue(8'h12, 8'hF0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("abort_ovf", ovf, 0);
`endif
    $display("reset: aborted op at bit 4");
    void'(sb.pop_back());
    held_diff = '0;
    held_bout = 1'b0;
    held_ovf  = 1'b0;
    busy_from = -1;
    busy_to   = -1;
    free_cyc  = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(8'd200, 8'd55, 1'b0);

    // Random operations with occasional idle gaps.
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
